instr_fetch_unit: RTL

//  Instruction-fetch stage; produces the 32-bit instruction word that feeds the IF_ID register of the

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: request/ready handshake plus a returning rvalid/rdata beat.
// The master side is the fetch unit and the slave side is the memory.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one read outstanding to instruction memory,
// buffers returned words and presents the buffer head (or a NOP bubble) to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic                      clock,
    input  logic                      resetGral,
    input  logic                      stall,
    input  logic                      branchTaken,
    input  logic [31:0]               branchTarget,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               instruction,
    output logic                      instrValid,
    output logic [31:0]               instrPc
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(BUF_DEPTH);
    localparam logic [31:0]      RESET_PC_A = {RESET_PC[31:2], 2'b00};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      buf_data_q [BUF_DEPTH];
    logic [31:0]      buf_pc_q   [BUF_DEPTH];

    logic has_word;
    logic req;
    logic accept;
    logic push;
    logic pop;
    logic [1:0] unused_target_bits;

    assign unused_target_bits = branchTarget[1:0];

    // Only one read is ever in flight, so in IDLE the occupancy alone decides whether a
    // returning word is guaranteed a free slot.
    assign has_word = (count_q != '0);
    assign req      = (state_q == S_IDLE) && !branchTaken && !resetGral && (count_q < DEPTH_C);
    assign accept   = req && imem.imem_ready;
    assign push     = (state_q == S_BUSY) && imem.imem_rvalid && !branchTaken;
    assign pop      = has_word && !stall && !branchTaken;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_BUSY;
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                end
            end
            S_BUSY: begin
                if (imem.imem_rvalid) begin
                    state_d = S_IDLE;
                end else if (branchTaken) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem.imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A redirect wipes every wrong-path word and retargets the next fetch.
        if (branchTaken) begin
            pc_d     = {branchTarget[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (resetGral) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC_A;
            req_pc_q <= RESET_PC_A;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= imem.imem_rdata;
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign instrValid     = has_word;
    assign instruction    = has_word ? buf_data_q[rd_ptr_q] : NOP_WORD;
    assign instrPc        = has_word ? buf_pc_q[rd_ptr_q] : 32'h0000_0000;

endmodule
